expr_generator: RTL
===================

# expr_generator

Produces the falling arithmetic expressions for the calculator game. Every period it draws a pseudo-random operand/operator/operand triple, legalises it, picks one of three display lines, and emits a one-cycle `update` pulse. The calculator core consumes this pulse to shift its expression slots and load the new entry. It sits directly upstream of the calculator core on the same `delay_clk` domain. The period shrinks as the player's score rises.

## Interface
- `PERIOD_INIT`, 200: `delay_clk` cycles between updates at score 0 (max 1023).
- `PERIOD_MIN`, 60: floor on the period (min 4).
- `PERIOD_STEP`, 10: period reduction per 8 points of score.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (non-zero).
- `delay_clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-low.
- `enable  in  1`: game running; low freezes generation.
- `score  in  7`: current score from the calculator core.
- `tmp_exp  out  12`: expression word: [11:8] operand A, [7:4] operator (A add, B sub, C mul, D div), [3:0] operand B.
- `line  out  2`: target line, 0..2.
- `update  out  1`: one-cycle pulse; `tmp_exp` and `line` are valid while it is high.

## Operation
- **LFSR.** 16-bit Galois LFSR with polynomial mask 16'hB400. It steps on every `delay_clk` edge out of reset, regardless of `enable`.
- **IDLE.** `update` is 0. Go to WAIT when `enable` is 1, loading `cnt` = P−4.
- **WAIT.** Decrement `cnt`. Go to DRAW when `cnt` is 0.
- **DRAW.** Capture from the LFSR:
  - a = lfsr[3:0], b = lfsr[7:4];
  - op = 4'hA + lfsr[9:8];
  - ln = lfsr[11:10]. If ln is 3, use (last_line+1) mod 3 instead.
- **FIX.** Legalise the captured triple:
  - sub with a<b: swap a and b, so results are never negative;
  - div with b=0: set b=1. Division truncates; the calculator core computes the same truncated quotient;
  - add and mul are unchanged. The maximum result is 225, which fits the core's 8-bit answer;
  - a=0 is legal. `tmp_exp` is never 12'h000 because op ≥ A.
- **EMIT.**
  - Register `tmp_exp` = {a,op,b}, `line` = ln, `update` = 1, and set last_line = ln.
  - Compute the next period: P = max(PERIOD_MIN, PERIOD_INIT − PERIOD_STEP·score[6:3]). Use saturating subtraction; a negative result clamps to PERIOD_MIN. `score` is sampled only in this state.
  - Go to WAIT with `cnt` = P−4.
- **enable low** in any non-IDLE state: return to IDLE on the next edge. No pulse is emitted, even from DRAW or FIX. `tmp_exp` and `line` hold their last values.
- **Reset values:** `tmp_exp` = 0, `line` = 0, `update` = 0, state IDLE, last_line = 2, LFSR = `LFSR_SEED`, P = `PERIOD_INIT`.

## Timing
- `update` is high for exactly one `delay_clk` cycle. The consumer samples it on the following edge.
- In steady state with `enable` held high, consecutive `update` rising edges are exactly P cycles apart:
  - WAIT lasts P−3 cycles, counting the cnt=0 cycle;
  - DRAW, FIX and EMIT take one cycle each.
- **First pulse:** if `enable` is first sampled high at edge e, `update` is high in the cycle following edge e+P−1.
- A new P takes effect from the interval that begins at the EMIT where it was computed.
- **Asynchronous reset mid-operation:** all outputs go to their reset values immediately, with no glitch pulse. Generation restarts through IDLE.
- Widths: `cnt` and P are 10-bit unsigned. PERIOD_STEP·score[6:3] is computed in 10 bits.

## Structure
- Package `calc_pkg` holds:
  - OP_ADD/SUB/MUL/DIV = 4'hA..4'hD;
  - expression field bit positions (A [11:8], OP [7:4], B [3:0]);
  - the state enum (IDLE, WAIT, DRAW, FIX, EMIT).
- The calculator core imports the same package.
- One sub-module, `lfsr16`, with seed parameter, clock, reset, and 16-bit state output.

## Test plan
- **Reset values.** Reset asserted, then released with `enable`=0 for 500 cycles -> `tmp_exp`=0, `line`=0, `update` never high.
- **Score 0 spacing.** `enable`=1, `score`=0 -> first pulse at edge e+200; the next ten pulses each spaced exactly 200 cycles.
- **Period scaling.** `score`=40 from the start -> first interval 200, then 150. `score`=127 -> 200−150=50 clamps to 60, so spacing is 60.
- **Field invariants.** 1000 pulses, with a checker on every one -> op ∈ {A,B,C,D}; a ≥ b when op=B; b ≠ 0 when op=D; `line` ≤ 2; `tmp_exp` ≠ 0.
- **Enable drop.** Drop `enable` 5 cycles before an expected pulse -> no pulse. Re-raise -> next pulse exactly P cycles after the re-raise edge.
- **Reset mid-EMIT.** Assert `rst` while `update`=1 -> `update` and `tmp_exp` are 0 asynchronously. After release, the LFSR restarts from `LFSR_SEED` and the first `tmp_exp` equals the value from the first post-reset run.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator game: operator codes, expression
// word layout, the generator state encoding and the period helper.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam int unsigned EXP_FLD_W  = 4;
  localparam int unsigned EXP_A_LSB  = 8;
  localparam int unsigned EXP_OP_LSB = 4;
  localparam int unsigned EXP_B_LSB  = 0;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DRAW,
    FIX,
    EMIT
  } gen_state_e;

  // Saturating period: never below pmin, and a product larger than pinit
  // clamps rather than wrapping.
  function automatic logic [9:0] next_period(input logic [9:0] pinit,
                                             input logic [9:0] pmin,
                                             input logic [9:0] pstep,
                                             input logic [3:0] lvl);
    logic [9:0] dec;
    dec = pstep * {6'd0, lvl};
    if (dec > pinit) return pmin;
    if ((pinit - dec) < pmin) return pmin;
    return pinit - dec;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, shift-right form with the shared polynomial.
module lfsr16
  import calc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        delay_clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) state_d = state_d ^ LFSR_POLY;
  end

  always_ff @(posedge delay_clk or negedge rst) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/expr_generator.sv
// Periodic generator of legalised operand/operator/operand expressions with
// a score-dependent period and a one-cycle update pulse.
module expr_generator
  import calc_pkg::*;
#(
  parameter int unsigned PERIOD_INIT = 200,
  parameter int unsigned PERIOD_MIN  = 60,
  parameter int unsigned PERIOD_STEP = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        delay_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  score,
  output logic [11:0] tmp_exp,
  output logic [1:0]  line,
  output logic        update
);

  localparam logic [9:0] P_INIT = 10'(PERIOD_INIT);
  localparam logic [9:0] P_MIN  = 10'(PERIOD_MIN);
  localparam logic [9:0] P_STEP = 10'(PERIOD_STEP);

  logic [15:0] lfsr;
  logic        bits_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .delay_clk(delay_clk),
    .rst      (rst),
    .state_o  (lfsr)
  );

  assign bits_unused = ^{lfsr[15:12], score[2:0]};

  gen_state_e  state_q;
  logic [9:0]  cnt_q, period_q, period_d;
  logic [3:0]  a_q, b_q, op_q, a_d, b_d;
  logic [1:0]  ln_q, ln_d, last_line_q, line_q;
  logic [11:0] tmp_exp_q;
  logic        update_q;

  always_comb begin
    ln_d = lfsr[11:10];
    if (ln_d == 2'd3) ln_d = (last_line_q == 2'd2) ? 2'd0 : last_line_q + 2'd1;
    a_d = a_q;
    b_d = b_q;
    if (op_q == OP_SUB && a_q < b_q) begin
      a_d = b_q;
      b_d = a_q;
    end
    if (op_q == OP_DIV && b_q == '0) b_d = 4'd1;
    period_d = next_period(P_INIT, P_MIN, P_STEP, score[6:3]);
  end

  // Outputs are loaded on the FIX->EMIT edge so update is high during EMIT.
  always_ff @(posedge delay_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= P_INIT;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      ln_q        <= '0;
      last_line_q <= 2'd2;
      tmp_exp_q   <= '0;
      line_q      <= '0;
      update_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (state_q != IDLE && !enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (enable) begin
            state_q <= WAIT;
            cnt_q   <= period_q - 10'd4;
          end
          WAIT: begin
            if (cnt_q == '0) state_q <= DRAW;
            else             cnt_q   <= cnt_q - 10'd1;
          end
          DRAW: begin
            a_q     <= lfsr[3:0];
            b_q     <= lfsr[7:4];
            op_q    <= OP_ADD + {2'b00, lfsr[9:8]};
            ln_q    <= ln_d;
            state_q <= FIX;
          end
          FIX: begin
            tmp_exp_q   <= {a_d, op_q, b_d};
            line_q      <= ln_q;
            last_line_q <= ln_q;
            update_q    <= 1'b1;
            state_q     <= EMIT;
          end
          EMIT: begin
            period_q <= period_d;
            cnt_q    <= period_d - 10'd4;
            state_q  <= WAIT;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tmp_exp = tmp_exp_q;
  assign line    = line_q;
  assign update  = update_q;

endmodule
